// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types for the shift sequencer and barrel shifter
package shift_pkg;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ROL = 2'b10,
        ROR = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - combinational single-step shifter, amount 0..WIDTH-1
module barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(WIDTH)-1:0] i_amt,
    input  shift_type_e              i_type,
    output logic [WIDTH-1:0]         o_data
);

    // A zero amount makes the complementary shift WIDTH, which yields zero.
    always_comb begin
        o_data = i_data;
        case (i_type)
            LSL:     o_data = i_data << i_amt;
            LSR:     o_data = i_data >> i_amt;
            ROL:     o_data = (i_data << i_amt) | (i_data >> (WIDTH - 32'(i_amt)));
            ROR:     o_data = (i_data >> i_amt) | (i_data << (WIDTH - 32'(i_amt)));
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift front-end; SHIFT_SEQ_FASTPATH_EN shortens latency
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    seq_state_e       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [AMT_W-1:0] r_rem;
    shift_type_e      r_typ;

    seq_state_e       w_state_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [AMT_W-1:0] w_rem_nxt;
    shift_type_e      w_typ_nxt;
    shift_type_e      w_in_type;
    logic [SW-1:0]    w_step;
    logic [AMT_W-1:0] w_rem_after;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_load_acc;
    logic [AMT_W-1:0] w_load_rem;

    assign w_in_type   = shift_type_e'(in_type);
    assign w_step      = (32'(r_rem) > WIDTH - 1) ? SW'(WIDTH - 1) : r_rem[SW-1:0];
    assign w_rem_after = r_rem - AMT_W'(w_step);

    barrel_shifter #(.WIDTH(WIDTH)) u_barrel_shifter (
        .i_data (r_acc),
        .i_amt  (w_step),
        .i_type (r_typ),
        .o_data (w_shifted)
    );

`ifdef SHIFT_SEQ_FASTPATH_EN
    // Rotates reduce modulo WIDTH; over-long logical shifts resolve to zero at once.
    always_comb begin
        w_load_acc = in_data;
        w_load_rem = in_amt;
        if (w_in_type == ROL || w_in_type == ROR) begin
            w_load_rem = AMT_W'(in_amt[SW-1:0]);
        end else if (32'(in_amt) >= WIDTH) begin
            w_load_acc = '0;
            w_load_rem = '0;
        end
    end
`else
    assign w_load_acc = in_data;
    assign w_load_rem = in_amt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_rem;
        w_typ_nxt   = r_typ;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_acc_nxt   = w_load_acc;
                    w_rem_nxt   = w_load_rem;
                    w_typ_nxt   = w_in_type;
                    w_state_nxt = (w_load_rem != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                w_acc_nxt = w_shifted;
                w_rem_nxt = w_rem_after;
                if (w_rem_after == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_typ   <= LSL;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_rem   <= w_rem_nxt;
            r_typ   <= w_typ_nxt;
        end
    end

    assign out_data = r_acc;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed and randomized checks of shift_sequencer against a reference model
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [5:0] in_amt;
    logic [1:0] in_type;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(8), .AMT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_type   (in_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result: logical shifts past the width clear, rotates wrap modulo 8.
    function automatic logic [7:0] model_data(input logic [7:0] d, input int amt, input int typ);
        logic [7:0] r;
        r = d;
        case (typ)
            0: r = (amt >= 8) ? 8'h00 : 8'(d << amt);
            1: r = (amt >= 8) ? 8'h00 : 8'(d >> amt);
            2: for (int i = 0; i < amt % 8; i++) r = {r[6:0], r[7]};
            default: for (int i = 0; i < amt % 8; i++) r = {r[0], r[7:1]};
        endcase
        return r;
    endfunction

    // Cycles from the handshake edge to the first cycle with out_valid high.
    function automatic int model_lat(input int amt, input int typ);
`ifdef SHIFT_SEQ_FASTPATH_EN
        if (typ >= 2) return 1 + ((amt % 8) + 6) / 7;
        if (amt >= 8) return 1;
`endif
        return 1 + (amt + 6) / 7;
    endfunction

    task automatic run_cmd(input string tag, input logic [7:0] d, input int amt, input int typ,
                           input int hold, input logic [7:0] exp_data, input int exp_lat);
        int         lat;
        logic [7:0] held;
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = 6'(amt);
        in_type   = 2'(typ);
        tick();
        in_data   = ~d;
        in_amt    = 6'($urandom_range(0, 63));
        in_type   = 2'($urandom_range(0, 3));
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".data"}, 32'(out_data), 32'(exp_data));
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_data"}, 32'(out_data), 32'(held));
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold_busy"}, 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".post_busy"}, 32'(busy), 32'd0);
        check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int amt;
        int typ;
        logic [7:0] d;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = 6'd0;
        in_type   = 2'b00;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        tick();

        run_cmd("lsl2", 8'b10110011, 2, 0, 0, 8'b11001100, 2);
`ifdef SHIFT_SEQ_FASTPATH_EN
        run_cmd("ror10", 8'b10110011, 10, 3, 0, 8'b11101100, 2);
        run_cmd("lsr20", 8'b10110011, 20, 1, 0, 8'b00000000, 1);
`else
        run_cmd("ror10", 8'b10110011, 10, 3, 0, 8'b11101100, 3);
        run_cmd("lsr20", 8'b10110011, 20, 1, 0, 8'b00000000, 4);
`endif
        run_cmd("rol0", 8'b10110011, 0, 2, 0, 8'b10110011, 1);
        run_cmd("backpressure", 8'b10110011, 13, 2, 5, model_data(8'b10110011, 13, 2),
                model_lat(13, 2));

`ifndef SHIFT_SEQ_FASTPATH_EN
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        in_amt    = 6'd40;
        in_type   = 2'b00;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrun_rst.out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst.busy", 32'(busy), 32'd0);
        check("midrun_rst.in_ready", 32'(in_ready), 32'd1);
        check("midrun_rst.out_data", 32'(out_data), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("midrun_rst.no_result", 32'(out_valid), 32'd0);
        end
`endif

        for (int n = 0; n < 40; n++) begin
            d   = 8'($urandom);
            amt = $urandom_range(0, 63);
            typ = $urandom_range(0, 3);
            run_cmd("random", d, amt, typ, $urandom_range(0, 3), model_data(d, amt, typ),
                    model_lat(amt, typ));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

- Sequential command front-end for the combinational `barrel_shifter`.
- Accepts shift commands over a valid/ready handshake. Total shift amounts may exceed `WIDTH-1`.
- Splits each command into per-cycle steps of at most `WIDTH-1` and feeds the shifter output back until the amount is consumed.
- Presents the result on a valid/ready output port.

## Interface
- `WIDTH`, default 8: data width. Must be a power of two, ≥ 4.
- `AMT_W`, default 6: width of the requested total shift amount.
- `clk  in  1`: clock, rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `in_valid  in  1`: command valid.
- `in_ready  out  1`: command accepted when `in_valid && in_ready`.
- `in_data  in  WIDTH`: operand.
- `in_amt  in  AMT_W`: total shift amount.
- `in_type  in  2`: `00` LSL, `01` LSR, `10` ROL, `11` ROR.
- `out_valid  out  1`: result valid.
- `out_ready  in  1`: consumer ready.
- `out_data  out  WIDTH`: result.
- `busy  out  1`: high when the state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready=1`.
  - On handshake, latch `in_data` into `acc`, the effective amount into `rem`, and `in_type` into `typ`.
  - Next state is RUN if `rem≠0`, else DONE.
- **RUN**
  - `step = min(rem, WIDTH-1)`.
  - `acc <= barrel_shifter(acc, step, typ)`.
  - `rem <= rem - step`.
  - Go to DONE when `rem - step == 0`.
- **DONE**
  - `out_valid=1` and `out_data=acc`.
  - On `out_ready`, go to IDLE.
  - `acc` is held stable while `out_ready` is low.
- `in_ready` is high only in IDLE. A new command is never accepted in the same cycle a result is consumed.
- `in_type` is not re-sampled after acceptance. Input changes during RUN/DONE are ignored.
- Arithmetic rules:
  - `rem` is `AMT_W` bits and only decrements, so it cannot underflow.
  - `step` fits `$clog2(WIDTH)` bits.
  - Logical shifts fill with zeros.
  - Rotates are exact modulo `WIDTH`.

## Timing
- Handshake in cycle T.
- With k = number of RUN steps, `out_valid` rises at T+1+k. If k=0, it rises at T+1.
- Result consumed in cycle D. The block is IDLE with `in_ready=1` at D+1.
- Minimum command period: 2 cycles (k=0, `out_ready` tied high).
- Reset values, effective the cycle after `rst_n` is sampled low:
  - state IDLE, `in_ready=1`.
  - `out_valid=0`, `busy=0`.
  - `out_data`=0, `acc`=0, `rem`=0.
- Reset mid-RUN or mid-DONE abandons the command. No output handshake occurs for it.
- Reset has priority over any simultaneous handshake.

## Configuration
- `SHIFT_SEQ_FASTPATH_EN` defined:
  - The effective amount is computed at acceptance.
  - For rotates: `in_amt mod WIDTH`.
  - For logical shifts with `in_amt ≥ WIDTH`: `acc` is loaded with 0, `rem` is set to 0, and the FSM goes straight to DONE at T+1.
  - Otherwise the amount is `in_amt`.
- `SHIFT_SEQ_FASTPATH_EN` undefined: the effective amount is always `in_amt`, and the block iterates the full count.
- `out_data` values are identical in both builds. Only latency differs.

## Structure
- Package `shift_pkg`:
  - `shift_type_e` enum (LSL=2'b00, LSR=2'b01, ROL=2'b10, ROR=2'b11).
  - `seq_state_e` enum (IDLE, RUN, DONE).
- One sub-module: `barrel_shifter #(.WIDTH(WIDTH))`.
  - Instantiated once and driven combinationally from `acc`, `step`, `typ`.
  - Output feeds back to `acc`.
- The remaining logic (FSM, `rem`, `acc`) lives in this module.

## Test plan
All scenarios use `WIDTH=8`, `AMT_W=6`.
- LSL: `in_data=8'b10110011`, `in_amt=2`, `in_type=00`, `out_ready=1` → `out_valid` at T+2, `out_data=8'b11001100`.
- ROR 10 on `8'b10110011` → `out_data=8'b11101100`.
  - With FASTPATH: at T+2.
  - Without FASTPATH: at T+3 (steps 7, 3).
- LSR 20 on `8'b10110011` → `out_data=8'b00000000`.
  - With FASTPATH: at T+1.
  - Without FASTPATH: at T+4 (steps 7, 7, 6).
- `in_amt=0`, ROL → `out_valid` at T+1, `out_data=8'b10110011`.
- Backpressure: `out_ready=0` for 5 cycles in DONE.
  - `out_data` stays stable; `in_ready=0` and `busy=1` throughout.
  - Once `out_ready=1`, `in_ready=1` the next cycle.
- Reset mid-RUN: LSL 40 (no FASTPATH), `rst_n=0` for one cycle in the 2nd RUN cycle.
  - Next cycle: `out_valid=0`, `busy=0`, `in_ready=1`, `out_data=0`.
  - No result is ever emitted for that command.
